// File: rtl/fetch_queue.sv
// In-order fetch queue between the PC/fetch stage and decode; flushed by pcSrc.
// Optional macro FETCHQ_BYPASS_EN: an empty queue forwards the input straight to decode.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AW-1:0]          inAddr,
   input  logic [AW-1:0]          inInstr,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic                   pcSrc,
   output logic [AW-1:0]          outAddr,
   output logic [AW-1:0]          outInstr,
   output logic                   outFault,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [$clog2(DEPTH):0] count
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

   logic [AW-1:0]    addr_mem_q  [DEPTH];
   logic [AW-1:0]    instr_mem_q [DEPTH];
   logic [DEPTH-1:0] fault_mem_q;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          full, q_valid, push, pop;

   // Pointer difference modulo 2*DEPTH yields occupancy 0..DEPTH directly.
   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == FULL_CNT);
   assign inReady = reset && !full && !pcSrc;
   assign q_valid = (count != '0) && !pcSrc;
   assign pop     = q_valid && outReady;

`ifdef FETCHQ_BYPASS_EN
   logic bypass;

   // An empty queue with a waiting consumer hands the entry over without storing it.
   assign bypass   = reset && (count == '0) && !pcSrc && inValid && outReady;
   assign push     = inValid && inReady && !bypass;
   assign outValid = q_valid || bypass;

   always_comb begin
      outAddr  = addr_mem_q[rd_ptr_q[IW-1:0]];
      outInstr = instr_mem_q[rd_ptr_q[IW-1:0]];
      outFault = fault_mem_q[rd_ptr_q[IW-1:0]];
      if (bypass) begin
         outAddr  = inAddr;
         outInstr = inInstr;
         outFault = (inAddr[1:0] != 2'b00);
      end
   end
`else
   assign push     = inValid && inReady;
   assign outValid = q_valid;
   assign outAddr  = addr_mem_q[rd_ptr_q[IW-1:0]];
   assign outInstr = instr_mem_q[rd_ptr_q[IW-1:0]];
   assign outFault = fault_mem_q[rd_ptr_q[IW-1:0]];
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (pcSrc) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !pcSrc) begin
         addr_mem_q[wr_ptr_q[IW-1:0]]  <= inAddr;
         instr_mem_q[wr_ptr_q[IW-1:0]] <= inInstr;
         fault_mem_q[wr_ptr_q[IW-1:0]] <= (inAddr[1:0] != 2'b00);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, AW=32); honours FETCHQ_BYPASS_EN if defined.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
`ifdef FETCHQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] inAddr = '0;
   logic [AW-1:0] inInstr = '0;
   logic          inValid = 1'b0;
   logic          inReady;
   logic          pcSrc = 1'b0;
   logic [AW-1:0] outAddr;
   logic [AW-1:0] outInstr;
   logic          outFault;
   logic          outValid;
   logic          outReady = 1'b0;
   logic [2:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } ent_t;

   ent_t sb[$];

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .inAddr(inAddr), .inInstr(inInstr), .inValid(inValid), .inReady(inReady),
      .pcSrc(pcSrc),
      .outAddr(outAddr), .outInstr(outInstr), .outFault(outFault),
      .outValid(outValid), .outReady(outReady),
      .count(count)
   );

   function automatic ent_t mk(input logic [31:0] a, input logic [31:0] i);
      ent_t e;
      e.addr  = a;
      e.instr = i;
      e.fault = (a[1:0] != 2'b00);
      return e;
   endfunction

   task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] ins,
                         input logic rdy, input logic f);
      inValid  = v;
      inAddr   = a;
      inInstr  = ins;
      outReady = rdy;
      pcSrc    = f;
      #1;
   endtask

   // Applies the reference behaviour for the current inputs to the scoreboard, then clocks.
   task automatic step();
      int sz;
      bit mv, mr, byp;
      sz  = sb.size();
      mv  = reset && !pcSrc && (sz != 0);
      mr  = reset && !pcSrc && (sz < DEPTH);
      byp = BYP && reset && !pcSrc && (sz == 0) && inValid && outReady;
      if (pcSrc) sb.delete();
      else begin
         if (mv && outReady) void'(sb.pop_front());
         if (inValid && mr && !byp) sb.push_back(mk(inAddr, inInstr));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         set_in(1'b1, base + 32'(4 * k), 32'h1000 + base + 32'(k), 1'b0, 1'b0);
         step();
      end
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = sb.size();
      for (int k = 0; k < n; k++) begin
         set_in(1'b0, '0, '0, 1'b1, 1'b0);
         n_checks++;
         if ({outValid, outAddr, outInstr, outFault} !== {1'b1, sb[0].addr, sb[0].instr, sb[0].fault}) begin
            n_fail++;
            $display("FAIL drain_head: got v=%b a=%h i=%h f=%b want a=%h i=%h f=%b",
                     outValid, outAddr, outInstr, outFault, sb[0].addr, sb[0].instr, sb[0].fault);
         end
         step();
      end
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL drain_count: got %0d want 0", count);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      set_in(1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({inReady, outValid, count} !== {1'b0, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_hold: got inReady=%b outValid=%b count=%0d want 0 0 0",
                  inReady, outValid, count);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 1", inReady);
      end
      step();
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({count, outValid, outAddr, outInstr, outFault} !== {3'd1, 1'b1, 32'h0, 32'h00000013, 1'b0}) begin
         n_fail++;
         $display("FAIL first_push: got c=%0d v=%b a=%h i=%h f=%b want 1 1 0 00000013 0",
                  count, outValid, outAddr, outInstr, outFault);
      end
      drain();
   endtask

   task automatic test_fill_full();
      push_n(32'h0, 4);
      set_in(1'b1, 32'd16, 32'h2016, 1'b0, 1'b0);
      n_checks++;
      if ({count, inReady} !== {3'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL full_state: got count=%0d inReady=%b want 4 0", count, inReady);
      end
      step();
      n_checks++;
      if (count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_ignore: got count=%0d want 4", count);
      end
      // First pop cycle while still offering: the freed slot must not be usable yet.
      set_in(1'b1, 32'd16, 32'h2016, 1'b1, 1'b0);
      n_checks++;
      if ({inReady, outValid, outAddr} !== {1'b0, 1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL full_pop: got inReady=%b v=%b a=%h want 0 1 00000000",
                  inReady, outValid, outAddr);
      end
      step();
      set_in(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({count, inReady} !== {3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL after_pop: got count=%0d inReady=%b want 3 1", count, inReady);
      end
      for (int k = 1; k < 4; k++) begin
         n_checks++;
         if ({outValid, outAddr} !== {1'b1, 32'(4 * k)} || outAddr !== sb[0].addr) begin
            n_fail++;
            $display("FAIL full_order: got v=%b a=%h want a=%h", outValid, outAddr, 32'(4 * k));
         end
         step();
      end
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({count, outValid} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL full_drained: got count=%0d v=%b want 0 0", count, outValid);
      end
   endtask

   task automatic test_back_to_back();
      push_n(32'h100, 2);
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 32'h200 + 32'(4 * k), 32'h3000 + 32'(k), 1'b1, 1'b0);
         n_checks++;
         if ({outValid, outAddr, outInstr} !== {1'b1, sb[0].addr, sb[0].instr}) begin
            n_fail++;
            $display("FAIL b2b_head: got v=%b a=%h i=%h want a=%h i=%h",
                     outValid, outAddr, outInstr, sb[0].addr, sb[0].instr);
         end
         step();
         n_checks++;
         if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", count);
         end
      end
      drain();
   endtask

   task automatic test_flush();
      push_n(32'h40, 3);
      set_in(1'b1, 32'd23, 32'h4023, 1'b1, 1'b1);
      n_checks++;
      if ({inReady, outValid} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_cycle: got inReady=%b outValid=%b want 0 0", inReady, outValid);
      end
      step();
      set_in(1'b1, 32'd44, 32'h4044, 1'b0, 1'b0);
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL flush_count: got %0d want 0", count);
      end
      step();
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({outValid, outAddr} !== {1'b1, 32'd44} || outInstr !== sb[0].instr) begin
         n_fail++;
         $display("FAIL flush_next_head: got v=%b a=%h i=%h want 1 0000002c %h",
                  outValid, outAddr, outInstr, sb[0].instr);
      end
      for (int k = 0; k < 2; k++) begin
         set_in(1'b1, 32'h60 + 32'(4 * k), 32'h6000, 1'b0, 1'b1);
         step();
      end
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({count, outValid} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL double_flush: got count=%0d v=%b want 0 0", count, outValid);
      end
   endtask

   task automatic test_misaligned();
      set_in(1'b1, 32'h17, 32'h5017, 1'b0, 1'b0);
      step();
      set_in(1'b1, 32'h18, 32'h5018, 1'b0, 1'b0);
      step();
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({outValid, outFault, outAddr} !== {1'b1, 1'b1, 32'h17}) begin
         n_fail++;
         $display("FAIL misaligned_head: got v=%b f=%b a=%h want 1 1 00000017",
                  outValid, outFault, outAddr);
      end
      set_in(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({outValid, outFault, outAddr} !== {1'b1, 1'b0, 32'h18}) begin
         n_fail++;
         $display("FAIL aligned_head: got v=%b f=%b a=%h want 1 0 00000018",
                  outValid, outFault, outAddr);
      end
      drain();
   endtask

   task automatic test_async_reset();
      push_n(32'h80, 3);
      n_checks++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL pre_reset_count: got %0d want 3", count);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({count, outValid, inReady} !== {3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got count=%0d v=%b inReady=%b want 0 0 0",
                  count, outValid, inReady);
      end
      sb.delete();
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_bypass();
      set_in(1'b1, 32'd8, 32'h7008, 1'b1, 1'b0);
      n_checks++;
      if (outValid !== BYP || (BYP && outAddr !== 32'd8)) begin
         n_fail++;
         $display("FAIL bypass_comb: got v=%b a=%h want v=%b a=00000008", outValid, outAddr, BYP);
      end
      step();
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if (count !== (BYP ? 3'd0 : 3'd1)) begin
         n_fail++;
         $display("FAIL bypass_count: got %0d want %0d", count, BYP ? 0 : 1);
      end
      drain();
      set_in(1'b1, 32'd12, 32'h700c, 1'b0, 1'b0);
      step();
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({count, outValid, outAddr} !== {3'd1, 1'b1, 32'd12}) begin
         n_fail++;
         $display("FAIL noready_push: got count=%0d v=%b a=%h want 1 1 0000000c",
                  count, outValid, outAddr);
      end
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fill_full();
      test_back_to_back();
      test_flush();
      test_misaligned();
      test_async_reset();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
